ifu_fetch: RTL

- Instruction fetch initiator that drives the word address of the combinational instruction memory and captures the returned word.
- Sits between the PC and the decode stage.
- Holds the PC, increments it by 4, and accepts branch/jump redirects.
- Buffers fetched {pc, instr} pairs in a 2-entry queue under a valid/ready handshake toward decode.

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/ifu_fetch_q2.sv | 60 ++++++
 rtl/ifu_fetch.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_AW_DEFAULT    = 10;
  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned Q_DEPTH          = 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential PC successor, wrapping modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/ifu_fetch_q2.sv
// Two-entry fetch queue. The head entry is held in its own register so the
// decode-facing payload comes straight from flops; slot1 backs it up.
module ifu_fetch_q2
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL = 2'(Q_DEPTH);

  fetch_entry_t slot1;
  logic         do_pop;
  logic         do_push;

  // A pop needs data; a push needs room unless a pop frees it in the same cycle.
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != FULL) || do_pop);
  end

  // Queue storage; on flush the data is kept so the outputs hold their value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head  <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == FULL) head <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == FULL) begin
            head  <= slot1;
            slot1 <= din;
          end else begin
            head  <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch initiator: owns the PC, addresses the combinational
// instruction memory, and queues {pc, instr} pairs toward decode.
// Optional build macro: IFU_FETCH_BOUNDS_CHECK_EN enables the sticky
// out-of-window / misaligned fetch fault.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned IM_AW    = IM_AW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_instr,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             fetch_fault
);

  fetch_state_t     state;
  fetch_state_t     state_n;
  logic [31:0]      pc;
  logic [31:0]      pc_n;
  logic [IM_AW-1:0] im_addr_n;
  logic             redirect_take;
  logic             pop_c;
  logic             want_push;
  logic             push_c;
  fetch_entry_t     q_din;
  fetch_entry_t     q_head;
  logic [1:0]       q_count;

`ifdef IFU_FETCH_BOUNDS_CHECK_EN
  localparam logic [31:0] WINDOW_BYTES = 32'(WORD_BYTES) << IM_AW;
  logic bad_pc;
  logic fault_n;
`endif

  assign out_valid = (q_count != 2'd0);
  assign out_pc    = q_head.pc;
  assign out_instr = q_head.instr;
  assign q_din     = '{pc: pc, instr: im_instr};

  // Next-state, PC and queue control; redirect outranks push and pop.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    redirect_take = redirect_en;
    pop_c         = 1'b0;
    want_push     = 1'b0;
    push_c        = 1'b0;
`ifdef IFU_FETCH_BOUNDS_CHECK_EN
    fault_n       = fetch_fault;
    redirect_take = redirect_en && (state != FAULT);
    bad_pc        = (pc[1:0] != 2'b00) || ((pc - PC_RESET) >= WINDOW_BYTES);
`endif
    pop_c     = out_valid && out_ready && !redirect_take;
    want_push = !redirect_take && (state != FAULT) &&
                ((q_count != 2'd2) || pop_c);
`ifdef IFU_FETCH_BOUNDS_CHECK_EN
    push_c    = want_push && !bad_pc;
`else
    push_c    = want_push;
`endif

    if (redirect_take) begin
      pc_n    = redirect_pc;
      state_n = FETCH;
`ifdef IFU_FETCH_BOUNDS_CHECK_EN
    end else if (want_push && bad_pc) begin
      state_n = FAULT;
      fault_n = 1'b1;
`endif
    end else if (state != FAULT) begin
      if (push_c) pc_n = next_pc(pc);
      if (((q_count == 2'd2) && !pop_c) ||
          ((q_count == 2'd1) && push_c && !pop_c)) state_n = HOLD;
      else                                         state_n = FETCH;
    end

    im_addr_n = IM_AW'((pc_n - PC_RESET) >> 2);
  end

  // State, PC and the registered memory address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= PC_RESET;
      im_addr <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      im_addr <= im_addr_n;
    end
  end

`ifdef IFU_FETCH_BOUNDS_CHECK_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) fetch_fault <= 1'b0;
    else       fetch_fault <= fault_n;
  end
`else
  assign fetch_fault = 1'b0;
`endif

  ifu_fetch_q2 u_q (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .flush (redirect_take),
    .din   (q_din),
    .head  (q_head),
    .count (q_count)
  );

endmodule
